// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM state type for the uart tx arbiter
package uart_pkg;

    localparam int DATA_W            = 8;
    localparam int START_TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
// req    : request vector, one bit per requester
// last   : index of the previous winner; search starts at last+1
// winner : first set req bit at or after last+1, wrapping modulo NUM_REQ
// valid  : at least one request is set
module rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last,
    output logic [IDW-1:0]     winner,
    output logic               valid
);

    logic [IDW-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        // Offsets 1..NUM_REQ visit every requester once, last itself at the end.
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IDW'((int'(last) + i) % NUM_REQ);
            if (!valid && req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart transmitter
// clock, reset : system clock, synchronous active-high reset
// req, req_data: per-requester level request and byte (requester i on [8i+7:8i])
// ack          : one-cycle pulse, byte of requester i accepted
// tx_start     : one-cycle start pulse to the transmitter
// tx_data      : byte presented to the transmitter
// tx_busy      : busy from the transmitter
// owner        : index of the current grant holder, qualified by owner_valid
// owner_valid  : high from grant until the transmitter finishes the byte
// tx_err       : one-cycle pulse when tx_busy never rose after a start
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = START_TIMEOUT_DEF,
    localparam int IDW          = $clog2(NUM_REQ)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic [IDW-1:0]            owner,
    output logic                      owner_valid,
    output logic                      tx_err
);

    localparam int CW = $clog2(START_TIMEOUT + 1);

    arb_state_t          state, state_n;
    logic [IDW-1:0]      last, last_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [NUM_REQ-1:0]  ack_n;
    logic                tx_start_n;
    logic [DATA_W-1:0]   tx_data_n;
    logic [IDW-1:0]      owner_n;
    logic                owner_valid_n;
    logic                tx_err_n;

    logic [IDW-1:0]      pick_winner;
    logic                pick_valid;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req),
        .last   (last),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            last        <= IDW'(NUM_REQ - 1);
            cnt         <= '0;
            ack         <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            owner       <= '0;
            owner_valid <= 1'b0;
            tx_err      <= 1'b0;
        end else begin
            state       <= state_n;
            last        <= last_n;
            cnt         <= cnt_n;
            ack         <= ack_n;
            tx_start    <= tx_start_n;
            tx_data     <= tx_data_n;
            owner       <= owner_n;
            owner_valid <= owner_valid_n;
            tx_err      <= tx_err_n;
        end
    end

    always_comb begin
        state_n       = state;
        last_n        = last;
        cnt_n         = cnt;
        ack_n         = '0;
        tx_start_n    = 1'b0;
        tx_data_n     = tx_data;
        owner_n       = owner;
        owner_valid_n = owner_valid;
        tx_err_n      = 1'b0;

        case (state)
            IDLE: begin
                // A transmitter still busy from before reset blocks any grant.
                if (pick_valid && !tx_busy) begin
                    tx_data_n     = req_data[int'(pick_winner)*DATA_W +: DATA_W];
                    owner_n       = pick_winner;
                    owner_valid_n = 1'b1;
                    last_n        = pick_winner;
                    ack_n         = NUM_REQ'(1) << pick_winner;
                    tx_start_n    = 1'b1;
                    state_n       = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_n   = '0;
                state_n = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_n = WAIT_DONE;
                end else if (cnt == CW'(START_TIMEOUT - 1)) begin
                    // Byte is dropped; its requester was already acked.
                    tx_err_n      = 1'b1;
                    owner_valid_n = 1'b0;
                    state_n       = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    owner_valid_n = 1'b0;
                    state_n       = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*8-1:0] req_data;
    logic           tx_busy;
    logic [N-1:0]   ack;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic [1:0]     owner;
    logic           owner_valid;
    logic           tx_err;

    uart_tx_arbiter #(
        .NUM_REQ       (N),
        .START_TIMEOUT (TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .owner       (owner),
        .owner_valid (owner_valid),
        .tx_err      (tx_err)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 0;

    // transmitter model and stimulus controls
    bit force_busy  = 0;
    bit auto_busy   = 1;
    bit rand_busy   = 0;
    bit rand_en     = 0;
    bit drop_on_ack = 1;
    int b_wait      = 0;
    int b_left      = 0;
    int b_len       = 0;

    // reference model: arbiter described as "edges elapsed since the grant"
    logic [N-1:0] m_ack    = '0;
    bit           m_start  = 0;
    logic [7:0]   m_data   = '0;
    int           m_owner  = 0;
    bit           m_valid  = 0;
    bit           m_err    = 0;
    int           m_last   = N - 1;
    bit           m_active = 0;
    bit           m_seen   = 0;
    int           m_n      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock) begin
        if (reset) begin
            m_ack = '0; m_start = 0; m_data = '0; m_owner = 0; m_valid = 0;
            m_err = 0; m_last = N - 1; m_active = 0; m_seen = 0; m_n = 0;
        end else begin
            m_ack = '0; m_start = 0; m_err = 0;
            if (m_active) begin
                m_n++;
                if (!m_seen) begin
                    // busy counts from the second edge after the grant; give up after TO tries
                    if (m_n >= 2 && tx_busy) m_seen = 1;
                    else if (m_n == TO + 1) begin
                        m_err = 1; m_valid = 0; m_active = 0;
                    end
                end else if (!tx_busy) begin
                    m_valid = 0; m_active = 0;
                end
            end else if (req != '0 && !tx_busy) begin
                int w;
                bit found;
                w = 0; found = 0;
                for (int k = 1; k <= N; k++) begin
                    if (!found && req[(m_last + k) % N]) begin
                        w = (m_last + k) % N;
                        found = 1;
                    end
                end
                m_owner = w; m_data = req_data[w*8 +: 8]; m_valid = 1; m_last = w;
                m_ack[w] = 1'b1; m_start = 1; m_active = 1; m_n = 0; m_seen = 0;
            end
        end
    end

    always @(negedge clock) begin
        if (mon_en) begin
            chk("cyc_ack", 32'(ack), 32'(m_ack));
            chk("cyc_tx_start", 32'(tx_start), 32'(m_start));
            chk("cyc_tx_data", 32'(tx_data), 32'(m_data));
            chk("cyc_owner", 32'(owner), 32'(m_owner));
            chk("cyc_owner_valid", 32'(owner_valid), 32'(m_valid));
            chk("cyc_tx_err", 32'(tx_err), 32'(m_err));
        end
    end

    task automatic step();
        @(negedge clock);
        if (b_left > 0) b_left--;
        if (b_wait > 0) begin
            b_wait--;
            if (b_wait == 0) b_left = b_len;
        end
        if (tx_start && auto_busy) begin
            if (rand_busy) begin
                b_wait = $urandom_range(1, 3);
                b_len  = $urandom_range(1, 12);
                if ($urandom_range(0, 19) == 0) b_wait = 0;
            end else begin
                b_wait = 2;
                b_len  = 10;
            end
        end
        tx_busy = force_busy | (b_left > 0);
        for (int i = 0; i < N; i++) begin
            if (ack[i]) begin
                if (drop_on_ack) req[i] = 1'b0;
                else if (rand_en) begin
                    if ($urandom_range(0, 1) == 1) begin
                        req[i] = 1'b1;
                        req_data[i*8 +: 8] = 8'($urandom);
                    end else req[i] = 1'b0;
                end
            end else if (rand_en) begin
                if (!req[i] && $urandom_range(0, 9) < 3) begin
                    req[i] = 1'b1;
                    req_data[i*8 +: 8] = 8'($urandom);
                end else if (req[i] && $urandom_range(0, 49) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_ack(input int limit, output int steps, output bit ok);
        ok = 0;
        steps = 0;
        while (steps < limit && !ok) begin
            step();
            steps++;
            if (ack != '0) ok = 1;
        end
    endtask

    task automatic expect_grant(input string name, input int exp_owner);
        int st;
        bit ok;
        wait_ack(60, st, ok);
        chk({name, "_seen"}, 32'(ok), 32'd1);
        if (ok) begin
            chk({name, "_owner"}, 32'(owner), 32'(exp_owner));
            chk({name, "_ack"}, 32'(ack), 32'(1) << exp_owner);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((owner_valid || tx_busy) && n < 100) begin
            step();
            n++;
        end
        chk("drain_idle", 32'(owner_valid | tx_busy), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, n, vcount, starts;
        bit ok;
        reset = 1'b1; req = '0; req_data = '0; tx_busy = 1'b0;
        step();
        mon_en = 1;
        step();
        step();
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_owner_valid", 32'(owner_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        reset = 1'b0;

        // single requester
        req_data[7:0] = 8'hA5;
        req = 4'b0001;
        wait_ack(20, st, ok);
        chk("t1_seen", 32'(ok), 32'd1);
        chk("t1_ack", 32'(ack), 32'h1);
        chk("t1_start", 32'(tx_start), 32'd1);
        chk("t1_data", 32'(tx_data), 32'hA5);
        chk("t1_owner", 32'(owner), 32'd0);
        vcount = 0; starts = 0;
        while (owner_valid && vcount < 60) begin
            vcount++;
            step();
            if (tx_start) starts++;
        end
        chk("t1_valid_cycles", 32'(vcount), 32'd13);
        chk("t1_extra_starts", 32'(starts), 32'd0);
        drain();

        // round-robin over four held requests
        do_reset();
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        drop_on_ack = 0;
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            expect_grant($sformatf("t2_b%0d", k), k % 4);
            chk($sformatf("t2_b%0d_data", k), 32'(tx_data), 32'h10 + 32'(k % 4));
        end
        req = '0;
        drain();

        // holes in the request vector
        drop_on_ack = 1;
        req = 4'b0011;
        expect_grant("t3_a", 0);
        expect_grant("t3_b", 1);
        drain();
        req = 4'b1001;
        expect_grant("t3_c", 3);
        expect_grant("t3_d", 0);
        drain();

        // transmitter busy across reset
        force_busy = 1;
        do_reset();
        req = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t4_hold_ack", 32'(ack), 32'd0);
            chk("t4_hold_start", 32'(tx_start), 32'd0);
        end
        force_busy = 0;
        wait_ack(20, st, ok);
        chk("t4_seen", 32'(ok), 32'd1);
        chk("t4_latency", 32'(st), 32'd2);
        chk("t4_owner", 32'(owner), 32'd1);
        drain();

        // start timeout
        auto_busy = 0;
        req = 4'b0100;
        expect_grant("t5_a", 2);
        n = 0;
        while (!tx_err && n < 40) begin
            step();
            n++;
        end
        chk("t5_err_delay", 32'(n), 32'd17);
        chk("t5_valid_drop", 32'(owner_valid), 32'd0);
        auto_busy = 1;
        req = 4'b0100;
        expect_grant("t5_b", 2);
        drain();

        // reset during WAIT_DONE
        drop_on_ack = 0;
        req = 4'b1111;
        wait_ack(60, st, ok);
        chk("t6_seen", 32'(ok), 32'd1);
        n = 0;
        while (!tx_busy && n < 20) begin
            step();
            n++;
        end
        chk("t6_busy_rose", 32'(tx_busy), 32'd1);
        step();
        reset = 1'b1;
        step();
        chk("t6_rst_ack", 32'(ack), 32'd0);
        chk("t6_rst_start", 32'(tx_start), 32'd0);
        chk("t6_rst_data", 32'(tx_data), 32'd0);
        chk("t6_rst_owner", 32'(owner), 32'd0);
        chk("t6_rst_valid", 32'(owner_valid), 32'd0);
        chk("t6_rst_err", 32'(tx_err), 32'd0);
        reset = 1'b0;
        expect_grant("t6_after", 0);
        req = '0;
        drain();

        // randomized traffic against the model
        do_reset();
        rand_busy = 1;
        rand_en = 1;
        repeat (3000) step();
        rand_en = 0;
        req = '0;
        drain();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares the single UART transmitter among NUM_REQ byte sources.
- Drives the transmitter's start and send_data inputs and watches its busy output.
- Sits between several requesters (command responder, status reporter, debug tap, ...) and the uart top-level.
- Sequences exactly one byte per grant and flags a transmitter that never goes busy.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDW, $clog2(NUM_REQ), width of owner index (derived; not overridden).
- START_TIMEOUT, 16, cycles to wait for tx_busy to rise after a start pulse before declaring error.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester level request; held until ack.
- req_data  input  NUM_REQ*8  byte of requester i on bits [8i+7:8i].
- ack  output  NUM_REQ  one-cycle pulse: byte of requester i accepted.
- tx_start  output  1  one-cycle start pulse to the transmitter's start input.
- tx_data  output  8  byte to the transmitter's send_data input.
- tx_busy  input  1  busy from the transmitter.
- owner  output  IDW  index of the current grant holder.
- owner_valid  output  1  high from grant until the transmitter finishes the byte.
- tx_err  output  1  one-cycle pulse on start timeout.

Behaviour:
- All outputs are registered.
- Reset values: ack=0, tx_start=0, tx_data=0, owner=0, owner_valid=0, tx_err=0, state=IDLE, last pointer=NUM_REQ-1 (requester 0 wins first), timeout counter=0.
- A reset asserted mid-operation aborts immediately to these values. No ack is issued for a byte that was not yet granted.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Grant only when |req and tx_busy==0. If tx_busy is high (a transfer from before reset), stay in IDLE.
  - Winner is the first set req bit searching upward from last+1, modulo NUM_REQ.
  - On the grant edge: latch req_data[winner] into tx_data, set owner=winner, owner_valid=1, last=winner; pulse ack[winner] and tx_start together in the following cycle; go to LAUNCH.
- LAUNCH: lasts 1 cycle. tx_start returns to 0, ack returns to 0, counter clears, go to WAIT_BUSY.
- WAIT_BUSY:
  - If tx_busy==1, go to WAIT_DONE.
  - Otherwise increment the counter. When counter reaches START_TIMEOUT-1 with tx_busy still low: pulse tx_err for 1 cycle, clear owner_valid, go to IDLE.
  - The failed byte is dropped and not retried; the requester has already been acked.
- WAIT_DONE: when tx_busy==0, clear owner_valid and go to IDLE. The next grant can occur on that same IDLE cycle.
- tx_data and owner stay stable from grant until the next grant. Only owner_valid qualifies them.
- Latency: req sampled in IDLE at edge E0 gives ack and tx_start high in cycle E0..E1.
- A requester deasserting req before grant simply loses eligibility; no error.
- A req held high after ack is treated as a new request for the next byte. Fairness still rotates to other requesters first.
- Exactly one ack bit is high at a time; ack is never asserted while tx_busy is high in IDLE.
- Unused upper req bits are not possible; NUM_REQ bounds all indexing.

Decomposition:
- Shared package uart_pkg holds:
  - the FSM state enum (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE);
  - the byte width constant DATA_W=8;
  - the default START_TIMEOUT.
- One natural sub-module: rr_pick, a combinational round-robin picker.
  - Inputs: req vector and last pointer.
  - Outputs: winner index and valid.
  - Reusable for a future rx-side dispatcher.

Test Plan:
1. Single requester: after reset, req=4'b0001, req_data[7:0]=8'hA5, model busy rises 2 cycles after start and lasts 10 cycles → ack=0001 and tx_start high in the same cycle, tx_data=A5, owner=0, owner_valid held high until busy falls, one start only.
2. Round-robin fairness: req=4'b1111 held for 8 bytes, data i=8'h10+i → grant order 0,1,2,3,0,1,2,3; acks never overlap; tx_data matches the owner each time.
3. Fairness with holes: last=1, req=4'b1001 → requester 3 granted before 0; then req=4'b0001 → 0 granted next.
4. Busy at idle: hold tx_busy=1 for 5 cycles after reset with req=4'b0010 → no ack or tx_start until the cycle after busy falls, then owner=1.
5. Start timeout: busy model disabled, req=4'b0100 → tx_err pulse exactly START_TIMEOUT cycles into WAIT_BUSY (16), owner_valid drops, next request is serviced normally.
6. Reset mid-transfer: assert reset in WAIT_DONE with req=4'b1111 → all outputs 0 next cycle; after release requester 0 is granted first.
